// File: rtl/step_move_sequencer.sv
// Command-driven stepper move controller: paces steps from a per-move period,
// walks the 8-entry coil phase table, tracks position and dwells after a move.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | coils off, waiting for a command
//   S_RUN  | issuing steps, one every latched period
//   S_HOLD | coils held on last pattern for the dwell; new command accepted
module step_move_sequencer #(
  parameter int COUNT_W     = 16,
  parameter int DIV_W       = 24,
  parameter int POS_W       = 16,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [COUNT_W-1:0]      cmd_steps,
  input  logic                    cmd_dir,
  input  logic                    cmd_half,
  input  logic [DIV_W-1:0]        cmd_period,
  input  logic                    abort,
  output logic [3:0]              coil_out,
  output logic                    step_pulse,
  output logic                    busy,
  output logic                    done,
  output logic signed [POS_W-1:0] position
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam bit HAS_HOLD = (HOLD_CYCLES > 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0]   per_m1_q, per_m1_d;
  logic [DIV_W-1:0]   per_cnt_q, per_cnt_d;
  logic [HOLD_W-1:0]  dwell_q, dwell_d;
  logic               dir_q, dir_d;
  logic               half_q, half_d;
  logic [3:0]         coil_q, coil_d;
  logic               step_q, step_d;
  logic               done_q, done_d;

  logic               accept;
  logic [2:0]         delta;
  logic [2:0]         idx_step;
  logic [POS_W-1:0]   pos_step;
  logic [DIV_W-1:0]   cmd_per_m1;
  state_t             rest_state;

  function automatic logic [3:0] phase_pat(input logic [2:0] i);
    case (i)
      3'd0:    phase_pat = 4'b0001;
      3'd1:    phase_pat = 4'b0011;
      3'd2:    phase_pat = 4'b0010;
      3'd3:    phase_pat = 4'b0110;
      3'd4:    phase_pat = 4'b0100;
      3'd5:    phase_pat = 4'b1100;
      3'd6:    phase_pat = 4'b1000;
      default: phase_pat = 4'b1001;
    endcase
  endfunction

  // With no dwell configured a finished move falls straight back to idle.
  assign rest_state = HAS_HOLD ? S_HOLD : S_IDLE;

  assign accept     = cmd_valid && (state_q != S_RUN);
  assign delta      = half_q ? 3'd1 : 3'd2;
  assign idx_step   = dir_q ? (idx_q + delta) : (idx_q - delta);
  assign pos_step   = dir_q ? (pos_q + POS_W'(delta)) : (pos_q - POS_W'(delta));
  assign cmd_per_m1 = (cmd_period == '0) ? '0 : (cmd_period - DIV_W'(1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pos_d     = pos_q;
    rem_d     = rem_q;
    per_m1_d  = per_m1_q;
    per_cnt_d = per_cnt_q;
    dwell_d   = dwell_q;
    dir_d     = dir_q;
    half_d    = half_q;
    coil_d    = coil_q;
    step_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        coil_d = 4'b0000;
      end

      S_RUN: begin
        if (abort) begin
          done_d  = 1'b1;
          state_d = rest_state;
          dwell_d = HOLD_LOAD;
        end else if (per_cnt_q == '0) begin
          per_cnt_d = per_m1_q;
          rem_d     = rem_q - COUNT_W'(1);
          idx_d     = idx_step;
          pos_d     = pos_step;
          step_d    = 1'b1;
          coil_d    = phase_pat(idx_step);
          if (rem_q == COUNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = rest_state;
            dwell_d = HOLD_LOAD;
          end
        end else begin
          per_cnt_d = per_cnt_q - DIV_W'(1);
        end
      end

      S_HOLD: begin
        if (dwell_q == '0) begin
          state_d = S_IDLE;
          coil_d  = 4'b0000;
        end else begin
          dwell_d = dwell_q - HOLD_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        coil_d  = 4'b0000;
      end
    endcase

    // A new command overrides whatever IDLE/HOLD would otherwise do.
    if (accept) begin
      dir_d     = cmd_dir;
      half_d    = cmd_half;
      per_m1_d  = cmd_per_m1;
      per_cnt_d = cmd_per_m1;
      rem_d     = cmd_steps;
      if (cmd_steps == '0) begin
        done_d  = 1'b1;
        state_d = rest_state;
        dwell_d = HOLD_LOAD;
        coil_d  = HAS_HOLD ? phase_pat(idx_q) : 4'b0000;
      end else begin
        state_d = S_RUN;
        coil_d  = phase_pat(idx_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      pos_q     <= '0;
      rem_q     <= '0;
      per_m1_q  <= '0;
      per_cnt_q <= '0;
      dwell_q   <= '0;
      dir_q     <= 1'b0;
      half_q    <= 1'b0;
      coil_q    <= 4'b0000;
      step_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pos_q     <= pos_d;
      rem_q     <= rem_d;
      per_m1_q  <= per_m1_d;
      per_cnt_q <= per_cnt_d;
      dwell_q   <= dwell_d;
      dir_q     <= dir_d;
      half_q    <= half_d;
      coil_q    <= coil_d;
      step_q    <= step_d;
      done_q    <= done_d;
    end
  end

  assign cmd_ready  = rst && (state_q != S_RUN);
  assign busy       = (state_q == S_RUN);
  assign coil_out   = coil_q;
  assign step_pulse = step_q;
  assign done       = done_q;
  assign position   = pos_q;

endmodule

// File: tb/tb_step_move_sequencer.sv
// Directed bench for step_move_sequencer with a 5-cycle dwell; expected
// patterns, pulse timing and positions are worked out by hand below.
module tb_step_move_sequencer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_steps;
  logic        cmd_dir;
  logic        cmd_half;
  logic [23:0] cmd_period;
  logic        abort;
  logic [3:0]  coil_out;
  logic        step_pulse;
  logic        busy;
  logic        done;
  logic [15:0] position;

  int n_chk  = 0;
  int n_fail = 0;

  step_move_sequencer #(
    .COUNT_W(16), .DIV_W(24), .POS_W(16), .HOLD_CYCLES(5)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_half(cmd_half),
    .cmd_period(cmd_period), .abort(abort),
    .coil_out(coil_out), .step_pulse(step_pulse), .busy(busy),
    .done(done), .position(position)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] steps, input logic dir, input logic half,
                      input logic [23:0] period);
    cmd_valid  = 1'b1;
    cmd_steps  = steps;
    cmd_dir    = dir;
    cmd_half   = half;
    cmd_period = period;
  endtask

  logic [3:0] t1_coil [4];
  logic [3:0] t2_coil [3];

  initial begin
    t1_coil = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    t2_coil = '{4'b1001, 4'b1000, 4'b1100};
    rst = 1'b0; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0;
    cmd_half = 1'b0; cmd_period = '0; abort = 1'b0;

    #3;
    check("rst_coil", coil_out, 4'b0000);
    check("rst_step", step_pulse, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_pos", position, 0);
    #9 rst = 1'b1;
    tick();
    check("ready_after_rst", cmd_ready, 1);

    // Full-step forward, 4 steps every 3 cycles: index 0->2->4->6->0.
    send(16'd4, 1'b1, 1'b0, 24'd3);
    tick();
    cmd_valid = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_ready_run", cmd_ready, 0);
    for (int k = 1; k <= 4; k++) begin
      tick(); check("t1_gap_a", step_pulse, 0);
      tick(); check("t1_gap_b", step_pulse, 0);
      tick();
      check("t1_step", step_pulse, 1);
      check("t1_coil", coil_out, t1_coil[k-1]);
      check("t1_pos", position, 2 * k);
      check("t1_done", done, (k == 4) ? 1 : 0);
    end
    check("t1_busy_end", busy, 0);
    check("t1_ready_hold", cmd_ready, 1);
    for (int h = 2; h <= 5; h++) begin
      tick();
      check("t1_hold_coil", coil_out, 4'b0001);
      check("t1_hold_ready", cmd_ready, 1);
      check("t1_hold_done", done, 0);
    end
    tick();
    check("t1_idle_coil", coil_out, 4'b0000);

    // Half-step reverse, period 1, from index 0 / position 8.
    send(16'd3, 1'b0, 1'b1, 24'd1);
    tick();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("t2_step", step_pulse, 1);
      check("t2_coil", coil_out, t2_coil[k-1]);
      check("t2_pos", position, 8 - k);
      check("t2_done", done, (k == 3) ? 1 : 0);
    end

    // Accept in hold cycle 2, then a command queued while busy (period 0).
    tick();
    check("t3_hold2_coil", coil_out, 4'b1100);
    send(16'd2, 1'b1, 1'b1, 24'd2);
    tick();
    check("t3_no_gap", coil_out, 4'b1100);
    check("t3_busy", busy, 1);
    send(16'd1, 1'b0, 1'b0, 24'd0);
    tick();
    check("t3_e1_step", step_pulse, 0);
    check("t3_busy_not_ready", cmd_ready, 0);
    tick();
    check("t3_e2_step", step_pulse, 1);
    check("t3_e2_coil", coil_out, 4'b1000);
    check("t3_e2_pos", position, 6);
    tick();
    check("t3_e3_step", step_pulse, 0);
    check("t3_e3_busy", busy, 1);
    tick();
    check("t3_e4_step", step_pulse, 1);
    check("t3_e4_coil", coil_out, 4'b1001);
    check("t3_e4_pos", position, 7);
    check("t3_e4_done", done, 1);
    tick();
    cmd_valid = 1'b0;
    check("t3_queued_accept", busy, 1);
    check("t3_queued_nostep", step_pulse, 0);
    tick();
    check("t3_p0_step", step_pulse, 1);
    check("t3_p0_coil", coil_out, 4'b1100);
    check("t3_p0_pos", position, 5);
    check("t3_p0_done", done, 1);

    // Abort on the cycle the period expires.
    send(16'd3, 1'b1, 1'b0, 24'd2);
    tick();
    cmd_valid = 1'b0;
    tick(); check("t4_e1_step", step_pulse, 0);
    tick();
    check("t4_e2_step", step_pulse, 1);
    check("t4_e2_pos", position, 7);
    tick(); check("t4_e3_step", step_pulse, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_nostep", step_pulse, 0);
    check("t4_abort_done", done, 1);
    check("t4_abort_busy", busy, 0);
    check("t4_abort_pos", position, 7);
    check("t4_abort_coil", coil_out, 4'b1001);

    // Zero-step command in hold, with abort high (ignored outside RUN).
    abort = 1'b1;
    send(16'd0, 1'b1, 1'b1, 24'd7);
    tick();
    cmd_valid = 1'b0;
    abort = 1'b0;
    check("t5_done", done, 1);
    check("t5_nostep", step_pulse, 0);
    check("t5_busy", busy, 0);
    check("t5_coil", coil_out, 4'b1001);
    tick();
    check("t5_done_clear", done, 0);
    check("t5_pos", position, 7);

    // Asynchronous reset mid-move.
    send(16'd5, 1'b1, 1'b1, 24'd4);
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    tick();
    check("t6_step", step_pulse, 1);
    check("t6_coil", coil_out, 4'b0001);
    check("t6_pos", position, 8);
    tick();
    #2 rst = 1'b0;
    #1;
    check("t6_async_coil", coil_out, 4'b0000);
    check("t6_async_busy", busy, 0);
    check("t6_async_pos", position, 0);
    check("t6_async_done", done, 0);
    #2 rst = 1'b1;
    tick();
    check("t6_post_done", done, 0);
    check("t6_post_ready", cmd_ready, 1);
    check("t6_post_coil", coil_out, 4'b0000);

    // Reverse from reset wraps position negative.
    send(16'd3, 1'b0, 1'b1, 24'd1);
    tick();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("t7_coil", coil_out, t2_coil[k-1]);
    end
    check("t7_pos_neg", position, 16'hFFFD);
    check("t7_done", done, 1);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/step_move_sequencer.md
Name: step_move_sequencer

Overview:
- Command-driven move controller for the stepper drive. Accepts one move per valid/ready handshake: step count, direction, step mode and step period.
- Generates the step timing internally, walks the 8-entry coil phase table and tracks absolute position.
- After each move, holds the coils energised for a programmable dwell, then de-energises them.
- Sits between the speed/mode selection logic (the command source) and the coil driver pins.

Parameters:
- COUNT_W, 16, width of the step-count field and remaining-step counter.
- DIV_W, 24, width of the step-period field and period counter, in clk cycles.
- POS_W, 16, width of the signed position counter, in half-step units.
- HOLD_CYCLES, 1000, dwell in clk cycles after a move completes before the coils drop to 0000; 0 means no dwell.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_steps  in  COUNT_W  number of steps to issue.
- cmd_dir  in  1  1 = forward (phase index +), 0 = reverse.
- cmd_half  in  1  1 = half-step (index ±1), 0 = full-step (index ±2).
- cmd_period  in  DIV_W  clk cycles per step; 0 is treated as 1.
- abort  in  1  stop the current move at the next clock edge.
- coil_out  out  4  coil drive pattern.
- step_pulse  out  1  one-cycle strobe per issued step.
- busy  out  1  high in RUN.
- done  out  1  one-cycle strobe at move completion or abort.
- position  out  POS_W  signed absolute position in half-steps; wraps modulo 2^POS_W.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, phase index 0, position 0, coil_out 0000, step_pulse 0, done 0, busy 0, all counters 0. cmd_ready is 1 once reset is released.
- Phase table, index 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
  - Index arithmetic is modulo 8.
  - Full-step mode keeps the existing index parity: even parity gives wave drive, odd gives two-phase drive.
- coil_out:
  - RUN and HOLD: table[index], registered.
  - IDLE: 0000.
- State IDLE, cmd_ready=1. An accept (cmd_valid & cmd_ready at an edge) performs all of the following:
  - latches steps, dir, half and max(period,1);
  - clears the period counter;
  - if steps == 0, goes to HOLD and pulses done on the next cycle, with no step issued;
  - otherwise goes to RUN.
- State RUN: cmd_ready=0, busy=1.
  - The period counter increments each cycle.
  - When the counter equals period-1:
    - the counter clears;
    - index moves ±1 (half) or ±2 (full) per dir;
    - position moves ±1 or ±2;
    - remaining decrements;
    - step_pulse=1 for that one cycle.
  - The first step occurs exactly `period` cycles after the accept edge. Later steps follow every `period` cycles.
  - When the step that brings remaining to 0 is issued: done=1 in the same cycle as step_pulse, and the next state is HOLD.
- State HOLD: cmd_ready=1, busy=0.
  - coil_out holds the last pattern; the dwell counter counts HOLD_CYCLES.
  - When the dwell expires, go to IDLE.
  - An accept during HOLD starts the new move immediately, from the current index, with no de-energise.
  - HOLD_CYCLES=0: go from RUN directly to IDLE, and coil_out is 0000 on the cycle after the last step.
- abort:
  - In RUN: no step is issued on that cycle even if the period expires, done pulses, and the next state is HOLD. Index and position keep their last values.
  - In IDLE or HOLD: ignored.
  - abort together with cmd_valid in IDLE or HOLD: the command is accepted.
- Index and position persist across moves. Only reset clears them.
- Position wraps silently at ±2^(POS_W-1).
- Reset asserted mid-move: immediate return to the reset values, and no done pulse.

Test Plan:
- Reset, then accept steps=4, dir=1, half=0, period=3 -> step_pulse at cycles 3, 6, 9, 12 after accept; index 0→2→4→6→0; coil_out 0010, 0100, 1000, 0001; done with the 4th pulse; position=8.
- Half-step reverse: steps=3, dir=0, half=1, period=1, from index 0 -> pulses on 3 consecutive cycles; index 7, 6, 5; coil_out 1001, 1000, 1100; position=-3.
- HOLD_CYCLES=5 after a move -> coil_out holds for 5 cycles, then 0000; cmd_ready=1 throughout HOLD; an accept in HOLD cycle 2 starts the move with no 0000 gap.
- Abort in RUN on the cycle the period expires -> no step_pulse that cycle, done=1, busy drops, position unchanged.
- Edge commands: steps=0 -> no step_pulse, done one cycle later; period=0 -> behaves as period=1; cmd_valid while busy -> not accepted until HOLD/IDLE.
- rst pulsed low asynchronously mid-move -> outputs return to reset values without waiting for a clk edge; no done; position=0.
